freelist_alloc_ctrl: RTL

Dispatch-side allocation controller for the physical-register free list. It tracks the number of free physical registers and grants dispatch ways in program order, only as far as registers are available. It also sequences branch recovery: it kills dispatch, pulses the free list's recovery enable, and holds a configurable drain stall. It sits between the decode/dispatch stage and `freelist`, and drives that block's `new_pr_en` and `br_recover_enable`.

---
 rtl/freelist_alloc_ctrl_pkg.sv | 16 +
 rtl/freelist_alloc_ctrl_if.sv | 43 ++++
 rtl/freelist_alloc_ctrl_prefix_grant.sv | 37 +++
 rtl/freelist_alloc_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/freelist_alloc_ctrl_pkg.sv
// Shared types and sizing for the free-list allocation controller.
// Optional FL_ALLOC_PERF_EN adds performance counters to the controller.
package freelist_alloc_ctrl_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2
    } FL_CTRL_STATE;

    localparam int FL_N_PHYS_REG   = 64;
    localparam int FL_N_ARCH_REG   = 32;
    localparam int FL_CNT_W        = $clog2(FL_N_PHYS_REG + 1);
    localparam int FL_RESET_COUNT  = FL_N_PHYS_REG - FL_N_ARCH_REG;

endpackage

// File: rtl/freelist_alloc_ctrl_if.sv
// Dispatch/retire/recovery signal bundle between decode and the allocation controller.
// Perf outputs exist only when FL_ALLOC_PERF_EN is defined.
interface freelist_alloc_ctrl_if #(
    parameter int W     = 3,
    parameter int CNT_W = freelist_alloc_ctrl_pkg::FL_CNT_W
);
    import freelist_alloc_ctrl_pkg::*;

    logic [W-1:0]     dispatch_valid_in;
    logic [W-1:0]     dispatch_req_in;
    logic [W-1:0]     retire_valid_in;
    logic             br_mispredict_in;
    logic [W-1:0]     dispatch_grant_out;
    logic             dispatch_stall_out;
    logic [W-1:0]     freelist_pr_en_out;
    logic             freelist_recover_out;
    logic             recovering_out;
    logic [CNT_W-1:0] free_count_out;
`ifdef FL_ALLOC_PERF_EN
    logic [31:0]      perf_stall_cycles_out;
    logic [15:0]      perf_recoveries_out;
    logic [CNT_W-1:0] perf_min_free_out;
`endif

    modport master (
        output dispatch_valid_in, dispatch_req_in, retire_valid_in, br_mispredict_in,
        input  dispatch_grant_out, dispatch_stall_out, freelist_pr_en_out,
        input  freelist_recover_out, recovering_out, free_count_out
`ifdef FL_ALLOC_PERF_EN
        , input perf_stall_cycles_out, perf_recoveries_out, perf_min_free_out
`endif
    );

    modport slave (
        input  dispatch_valid_in, dispatch_req_in, retire_valid_in, br_mispredict_in,
        output dispatch_grant_out, dispatch_stall_out, freelist_pr_en_out,
        output freelist_recover_out, recovering_out, free_count_out
`ifdef FL_ALLOC_PERF_EN
        , output perf_stall_cycles_out, perf_recoveries_out, perf_min_free_out
`endif
    );

endinterface

// File: rtl/freelist_alloc_ctrl_prefix_grant.sv
// In-order prefix grant: a way dispatches only if every valid way below it did and
// the running count of requesting ways still fits in the budget.
module alloc_prefix_grant
    import freelist_alloc_ctrl_pkg::*;
#(
    parameter int W     = 3,
    parameter int CNT_W = FL_CNT_W
) (
    input  logic [W-1:0]     i_valid,
    input  logic [W-1:0]     i_req,
    input  logic [CNT_W-1:0] i_budget,
    output logic [W-1:0]     o_grant
);

    logic [W-1:0]     w_need;
    logic [CNT_W-1:0] w_cum;
    logic             w_chain;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_need
            assign w_need[gi] = i_valid[gi] & i_req[gi];
        end
    endgenerate

    // w_chain drops at the first valid way that misses, so no later way can slip through.
    always_comb begin
        w_cum   = '0;
        w_chain = 1'b1;
        o_grant = '0;
        for (int k = 0; k < W; k++) begin
            w_cum      = w_cum + CNT_W'(w_need[k]);
            o_grant[k] = i_valid[k] & w_chain & (w_cum <= i_budget);
            w_chain    = w_chain & (~i_valid[k] | o_grant[k]);
        end
    end

endmodule

// File: rtl/freelist_alloc_ctrl.sv
// Free-list allocation controller: grants dispatch ways against the free count and
// sequences branch recovery (FLUSH pulse, then DRAIN stall). FL_ALLOC_PERF_EN adds perf counters.
module freelist_alloc_ctrl
    import freelist_alloc_ctrl_pkg::*;
#(
    parameter int SUPERSCALAR_WAYS = 3,
    parameter int N_PHYS_REG       = FL_N_PHYS_REG,
    parameter int N_ARCH_REG       = FL_N_ARCH_REG,
    parameter int RECOVER_STALL    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    freelist_alloc_ctrl_if.slave bus
);

    localparam int W       = SUPERSCALAR_WAYS;
    localparam int CNT_W   = $clog2(N_PHYS_REG + 1);
    localparam int DRAIN_W = (RECOVER_STALL > 1) ? $clog2(RECOVER_STALL) : 1;
    localparam logic [CNT_W-1:0]   RESET_COUNT = CNT_W'(N_PHYS_REG - N_ARCH_REG);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD  =
        (RECOVER_STALL > 0) ? DRAIN_W'(RECOVER_STALL - 1) : '0;

    FL_CTRL_STATE       r_state, w_state_next;
    logic [CNT_W-1:0]   r_count, w_count_next;
    logic [DRAIN_W-1:0] r_drain, w_drain_next;
    logic [W-1:0]       w_prefix, w_grant, w_pr_en;
    logic [CNT_W-1:0]   w_alloc_cnt, w_retire_cnt;
    logic               w_dispatch_ok, w_recover, w_recovering, w_stall;

    alloc_prefix_grant #(.W(W), .CNT_W(CNT_W)) u_prefix_grant (
        .i_valid  (bus.dispatch_valid_in),
        .i_req    (bus.dispatch_req_in),
        .i_budget (r_count),
        .o_grant  (w_prefix)
    );

    // Reset gates the combinational outputs too, so nothing dispatches while it is held.
    assign w_grant      = w_prefix & {W{w_dispatch_ok & reset}};
    assign w_pr_en      = w_grant & bus.dispatch_req_in;
    assign w_recovering = (r_state != NORMAL);
    assign w_stall      = ~reset | w_recovering | bus.br_mispredict_in |
                          (|(bus.dispatch_valid_in & ~w_grant));

    always_comb begin
        w_alloc_cnt  = '0;
        w_retire_cnt = '0;
        for (int k = 0; k < W; k++) begin
            w_alloc_cnt  = w_alloc_cnt  + CNT_W'(w_pr_en[k]);
            w_retire_cnt = w_retire_cnt + CNT_W'(bus.retire_valid_in[k]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= NORMAL;
            r_count <= RESET_COUNT;
            r_drain <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_drain <= w_drain_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_drain_next  = r_drain;
        w_count_next  = r_count - w_alloc_cnt + w_retire_cnt;
        w_dispatch_ok = 1'b0;
        w_recover     = 1'b0;
        case (r_state)
            NORMAL: begin
                w_dispatch_ok = ~bus.br_mispredict_in;
                if (bus.br_mispredict_in) w_state_next = FLUSH;
            end
            FLUSH: begin
                // Retires are dropped here: the free list rebuilds its own state on recovery.
                w_recover    = 1'b1;
                w_count_next = RESET_COUNT;
                if (bus.br_mispredict_in) begin
                    w_state_next = FLUSH;
                end else if (RECOVER_STALL == 0) begin
                    w_state_next = NORMAL;
                end else begin
                    w_state_next = DRAIN;
                    w_drain_next = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (bus.br_mispredict_in) begin
                    w_state_next = FLUSH;
                end else if (r_drain == '0) begin
                    w_state_next = NORMAL;
                end else begin
                    w_drain_next = r_drain - 1'b1;
                end
            end
            default: w_state_next = NORMAL;
        endcase
    end

    assign bus.dispatch_grant_out   = w_grant;
    assign bus.freelist_pr_en_out   = w_pr_en;
    assign bus.dispatch_stall_out   = w_stall;
    assign bus.freelist_recover_out = w_recover;
    assign bus.recovering_out       = w_recovering;
    assign bus.free_count_out       = r_count;

`ifdef FL_ALLOC_PERF_EN
    logic [31:0]      r_perf_stall;
    logic [15:0]      r_perf_recoveries;
    logic [CNT_W-1:0] r_perf_min;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_stall      <= '0;
            r_perf_recoveries <= '0;
            r_perf_min        <= RESET_COUNT;
        end else begin
            if (w_stall && (|bus.dispatch_valid_in)) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_state_next == FLUSH) r_perf_recoveries <= r_perf_recoveries + 16'd1;
            if (w_count_next < r_perf_min) r_perf_min <= w_count_next;
        end
    end

    assign bus.perf_stall_cycles_out = r_perf_stall;
    assign bus.perf_recoveries_out   = r_perf_recoveries;
    assign bus.perf_min_free_out     = r_perf_min;
`endif

endmodule
